pipe_issue: RTL and testbench

//  Issue stage feeding the 4-stage register/ALU/memory pipeline (operand read -> ALU -> regbank write -> mem write).

---
 rtl/pipe_issue_if.sv | 24 ++
 rtl/pipe_issue.sv | 163 ++++++++++++++++
 tb/tb_pipe_issue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_if.sv
// Handshake and issue bus between the instruction source and pipe_issue.
// The master drives instruction words and flush; the slave (pipe_issue) drives the decoded issue fields.
interface pipe_issue_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] instr_in;
   logic        issue_valid;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [3:0]  rd;
   logic [3:0]  func;
   logic [7:0]  addr;

   modport master (
      output flush, in_valid, instr_in,
      input  in_ready, issue_valid, rs1, rs2, rd, func, addr
   );

   modport slave (
      input  flush, in_valid, instr_in,
      output in_ready, issue_valid, rs1, rs2, rd, func, addr
   );
endinterface

// File: rtl/pipe_issue.sv
// Issue stage: instruction queue, decode, and RAW-hazard bubble insertion via an rd scoreboard.
// Optional ISSUE_STATS_EN adds saturating issue_cnt/stall_cnt ports.
module pipe_issue #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HAZ_WINDOW  = 3,
   parameter logic [3:0]  BUBBLE_FUNC = 4'hF
) (
   input  logic         clk,
   input  logic         rst_n,
   pipe_issue_if.slave  bus
`ifdef ISSUE_STATS_EN
   ,
   output logic [15:0]  issue_cnt,
   output logic [15:0]  stall_cnt
`endif
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [7:0] addr;
   } instr_t;

   instr_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_sb_vld [HAZ_WINDOW];
   logic [3:0]         r_sb_rd  [HAZ_WINDOW];

   logic               r_issue_valid;
   logic [3:0]         r_rs1, r_rs2, r_rd, r_func;
   logic [7:0]         r_addr;

   instr_t             w_head;
   logic               w_empty;
   logic               w_in_ready;
   logic               w_hazard;
   logic               w_push;
   logic               w_pop;

   assign w_head     = r_mem[r_rd_ptr];
   assign w_empty    = (r_count == '0);
   assign w_in_ready = (r_count < CNT_W'(DEPTH));
   assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
   assign w_pop      = !w_empty && !w_hazard && !bus.flush;

   // Head reads a register still in flight downstream
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < int'(HAZ_WINDOW); i++) begin
         if (r_sb_vld[i] && ((r_sb_rd[i] == w_head.rs1) || (r_sb_rd[i] == w_head.rs2)))
            w_hazard = 1'b1;
      end
   end

   // Queue storage; occupancy is tracked by r_count so contents need no reset
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= instr_t'(bus.instr_in);
   end

   // Pointers and fill count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Scoreboard shifts every edge; slot 0 records what issued at this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(HAZ_WINDOW); i++) begin
            r_sb_vld[i] <= 1'b0;
            r_sb_rd[i]  <= '0;
         end
      end else if (bus.flush) begin
         for (int i = 0; i < int'(HAZ_WINDOW); i++) begin
            r_sb_vld[i] <= 1'b0;
            r_sb_rd[i]  <= '0;
         end
      end else begin
         for (int i = int'(HAZ_WINDOW) - 1; i > 0; i--) begin
            r_sb_vld[i] <= r_sb_vld[i-1];
            r_sb_rd[i]  <= r_sb_rd[i-1];
         end
         r_sb_vld[0] <= w_pop;
         r_sb_rd[0]  <= w_head.rd;
      end
   end

   // Issue registers; bubbles only force func and valid, other fields hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_valid <= 1'b0;
         r_func        <= BUBBLE_FUNC;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_addr        <= '0;
      end else if (w_pop) begin
         r_issue_valid <= 1'b1;
         r_func        <= w_head.func;
         r_rs1         <= w_head.rs1;
         r_rs2         <= w_head.rs2;
         r_rd          <= w_head.rd;
         r_addr        <= w_head.addr;
      end else begin
         r_issue_valid <= 1'b0;
         r_func        <= BUBBLE_FUNC;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.issue_valid = r_issue_valid;
   assign bus.func        = r_func;
   assign bus.rs1         = r_rs1;
   assign bus.rs2         = r_rs2;
   assign bus.rd          = r_rd;
   assign bus.addr        = r_addr;

`ifdef ISSUE_STATS_EN
   logic [15:0] r_issue_cnt;
   logic [15:0] r_stall_cnt;

   // Saturating issue and stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else if (bus.flush) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pop && (r_issue_cnt != 16'hFFFF))
            r_issue_cnt <= r_issue_cnt + 16'd1;
         if (!w_empty && !w_pop && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign issue_cnt = r_issue_cnt;
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_issue.sv
// Directed bench for pipe_issue: reset, independent stream, RAW stall, full queue, wrap, flush, mid-run reset.
module tb_pipe_issue;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   pipe_issue_if bus ();

`ifdef ISSUE_STATS_EN
   logic [15:0] issue_cnt;
   logic [15:0] stall_cnt;
`endif

   pipe_issue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef ISSUE_STATS_EN
      ,
      .issue_cnt (issue_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] mk(input int f, input int rd, input int rs1,
                                      input int rs2, input int addr);
      mk = {4'(f), 4'(rd), 4'(rs1), 4'(rs2), 8'(addr)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_issue(input string tag, input logic [23:0] w);
      chk({tag, ".valid"}, 32'(bus.issue_valid), 32'd1);
      chk({tag, ".fields"}, 32'({bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}), 32'(w));
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, 32'(bus.issue_valid), 32'd0);
      chk({tag, ".func"}, 32'(bus.func), 32'hF);
   endtask

   task automatic push(input logic [23:0] w);
      bus.in_valid = 1'b1;
      bus.instr_in = w;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.instr_in = '0;
   endtask

   logic [23:0] w_a, w_b, w_p;
   logic [23:0] w_c [5];
   logic [23:0] w_g [3];

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.flush = 1'b0;
      idle();
      #12;
      // reset state
      chk_bubble("rst");
      chk("rst.ready", 32'(bus.in_ready), 32'd1);
      chk("rst.fields", 32'({bus.rd, bus.rs1, bus.rs2, bus.addr}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk_bubble("rst.idle");

      // independent stream, one issue per cycle after one cycle of latency
      for (int i = 0; i < 6; i++) begin
         push(mk(i, 10 + i, 3 + i, 5 + i, 125 + i));
         tick();
         if (i == 0) chk_bubble("stream.lat");
         else        chk_issue($sformatf("stream%0d", i - 1), mk(i - 1, 9 + i, 2 + i, 4 + i, 124 + i));
         chk("stream.ready", 32'(bus.in_ready), 32'd1);
      end
      idle();
      tick();
      chk_issue("stream5", mk(5, 15, 8, 10, 130));
      tick();
      chk_bubble("stream.end");
      chk("stream.hold", 32'({bus.rd, bus.addr}), 32'({4'd15, 8'd130}));
      tick(); tick(); tick();

      // RAW: dependent waits exactly three bubbles
      w_a = mk(1, 10, 1, 2, 8'h11);
      w_b = mk(2, 3, 10, 2, 8'h22);
      push(w_a);
      tick();
      push(w_b);
      tick();
      idle();
      chk_issue("raw.prod", w_a);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_bubble($sformatf("raw.bub%0d", i));
      end
      tick();
      chk_issue("raw.cons", w_b);
      tick(); tick(); tick(); tick();

      // Full: four consumers pile up behind a hazard, fifth held until first pop
      w_p = mk(3, 7, 0, 0, 1);
      for (int k = 0; k < 5; k++) w_c[k] = mk(4 + k, 8 + k, 7, 0, 8'h30 + k);
      push(w_p);
      tick();
      for (int k = 0; k < 4; k++) begin
         push(w_c[k]);
         tick();
         if (k == 0) chk_issue("full.prod", w_p);
         else        chk_bubble($sformatf("full.bub%0d", k));
      end
      push(w_c[4]);
      chk("full.ready0", 32'(bus.in_ready), 32'd0);
      tick();
      chk_issue("full.c0", w_c[0]);
      chk("full.ready1", 32'(bus.in_ready), 32'd1);
      tick();
      idle();
      chk_issue("full.c1", w_c[1]);
      for (int k = 2; k < 5; k++) begin
         tick();
         chk_issue($sformatf("full.c%0d", k), w_c[k]);
      end
      tick();
      chk_bubble("full.empty");
      tick(); tick(); tick();

      // Wrap: sustained push+pop, count stays 1
      for (int k = 0; k < 10; k++) begin
         push(mk(k % 8, k, 15, 15, 8'h40 + k));
         tick();
         if (k > 0) chk_issue($sformatf("wrap%0d", k - 1), mk((k - 1) % 8, k - 1, 15, 15, 8'h40 + k - 1));
         chk("wrap.ready", 32'(bus.in_ready), 32'd1);
      end
      idle();
      tick();
      chk_issue("wrap9", mk(1, 9, 15, 15, 8'h49));
      tick(); tick(); tick(); tick();

      // Flush with three words queued behind a hazard
      w_p = mk(5, 5, 15, 15, 8'h50);
      for (int k = 0; k < 3; k++) w_g[k] = mk(6, 1 + k, 5, 15, 8'h60 + k);
      push(w_p);
      tick();
      for (int k = 0; k < 3; k++) begin
         push(w_g[k]);
         tick();
      end
      push(mk(7, 4, 14, 14, 8'h70));
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      idle();
      chk_bubble("flush.next");
      chk("flush.ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("flush.quiet", 32'(bus.issue_valid), 32'd0);
      end
      push(mk(9, 6, 5, 5, 8'h77));
      tick();
      idle();
      tick();
      chk_issue("flush.after", mk(9, 6, 5, 5, 8'h77));
      tick(); tick(); tick();

      // Reset mid-operation discards queued work
      push(mk(1, 1, 15, 15, 8'h81));
      tick();
      push(mk(2, 2, 15, 15, 8'h82));
      tick();
      push(mk(3, 3, 15, 15, 8'h83));
      tick();
      idle();
      chk_issue("mrst.pre", mk(2, 2, 15, 15, 8'h82));
      #2;
      rst_n = 1'b0;
      #1;
      chk_bubble("mrst.async");
      chk("mrst.ready", 32'(bus.in_ready), 32'd1);
      tick();
      tick();
      chk_bubble("mrst.held");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mrst.after", 32'(bus.issue_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
